ppu_out_packer: RTL and testbench
=================================

# ppu_out_packer

Packs the 8-bit activation stream from the post-processing unit (PPU) into 32-bit words and writes them to the global buffer (GLB). It sits directly downstream of the PPU and accepts one requantized uint8 byte per handshake. It assembles four bytes little-endian per word and drives a held write request with byte enables until the GLB accepts it. A run is bounded by a `start` pulse and a byte tagged `in_last`; a trailing partial word is flushed with masked lanes.

## Interface

- `ADDR_W`, default 16: GLB word-address width.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle pulse that begins a run. Ignored unless the block is IDLE.
- `base_addr`, input, ADDR_W: first GLB word address. Sampled on an accepted `start`.
- `in_valid`, input, 1: PPU byte valid.
- `in_ready`, output, 1: packer can accept a byte.
- `in_data`, input, 8: PPU `data_out` byte.
- `in_last`, input, 1: final byte of the run. Qualified by the input handshake.
- `glb_we`, output, 1: write request valid.
- `glb_ready`, input, 1: GLB accepts the write this cycle.
- `glb_addr`, output, ADDR_W: word address of the pending write.
- `glb_wdata`, output, 32: packed word. Byte k occupies bits [8k+7:8k].
- `glb_bwe`, output, 4: byte-write enables. Bit k set means lane k is valid.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the run is complete.

## Operation

- The FSM has four states: IDLE, ACTIVE, DRAIN and DONE.
- **IDLE:** `in_ready`=0. On `start`:
  - `wr_ptr` <= `base_addr`.
  - `lane_cnt` <= 0.
  - Go to ACTIVE.
- **ACTIVE:** `in_ready` = !`glb_we` | `glb_ready`. An input handshake (`in_valid` & `in_ready`) does the following:
  - Writes the byte into lane `lane_cnt` of the assembly register and sets that lane's enable bit.
  - If `lane_cnt`==3 or `in_last`, the word is complete:
    - Assembly data goes to `glb_wdata`, with unfilled lanes forced to 0x00.
    - Lane enables go to `glb_bwe`.
    - `glb_addr` <= `wr_ptr`; `wr_ptr` <= `wr_ptr`+1, modulo 2^ADDR_W.
    - `glb_we` <= 1.
    - Assembly data, enables and `lane_cnt` clear to 0.
  - Otherwise `lane_cnt` increments.
  - A handshake with `in_last` moves the FSM to DRAIN.
- **Output register:**
  - `glb_we`, `glb_addr`, `glb_wdata` and `glb_bwe` are held stable until `glb_we` & `glb_ready`.
  - On that handshake `glb_we` <= 0, unless a new word completes in the same cycle. In that case the new word loads and `glb_we` stays 1.
- **DRAIN:** `in_ready`=0. When `glb_we`=0, or the handshake `glb_we` & `glb_ready` occurs, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **`in_last` with no prior bytes in the word:** produces a word with `glb_bwe`=4'b0001.
- **`in_last` on the 4th lane:** produces a full word (`glb_bwe`=4'hF) and no extra flush.
- **Illegal stimulus:** `in_valid` while not ACTIVE is never consumed. `in_data` is never interpreted; it is packed verbatim.

## Timing

- **Reset:** asynchronous assertion forces the following immediately. Deassertion is synchronized externally.
  - State = IDLE.
  - `in_ready`, `glb_we`, `busy` and `done` = 0.
  - `glb_addr`, `glb_wdata`, `glb_bwe`, `wr_ptr` and `lane_cnt` = 0.
  - A run in progress is abandoned and pending partial data is discarded.
- **Start:** `start` at edge N puts the block in ACTIVE after that edge, so `in_ready` can be 1 in cycle N+1.
- **Write latency:** the byte that completes a word is handshaken at edge N, and `glb_we`=1 in cycle N+1. All outputs are registered; there is no combinational path from `in_data` to `glb_*`.
- **`in_ready` path:** combinational from `glb_ready` and state only, never from `in_valid`.
- **Throughput:** with `glb_ready` tied high there is one byte per cycle and one write per 4 cycles, with no bubbles.
- **Back-pressure:** while `glb_we`=1 and `glb_ready`=0, `in_ready`=0 and assembly is frozen. Lanes are stalled, not lost.
- **Done timing:** `done` rises the cycle after the final write handshake, or the cycle after the `in_last` handshake if no write was pending. `busy` falls with the return to IDLE.
- **Address wrap:** `wr_ptr` at 2^ADDR_W−1 wraps to 0 silently.

## Test plan

- **Full words:** `base_addr`=0x0010, `glb_ready`=1, 8 bytes 0x01..0x08 with `in_last` on 0x08.
  - Expect write {0x0010, 0x04030201, 4'hF}, then {0x0011, 0x08070605, 4'hF}.
  - `done` exactly 1 cycle after the 2nd write; `in_ready` never deasserted.
- **Partial flush:** 6 bytes 0xA0..0xA5 with `in_last` on the 6th.
  - Second write has `glb_wdata`=0x0000A5A4 and `glb_bwe`=4'b0011.
  - Single-byte run with 0x7F gives `glb_wdata`=0x0000007F and `glb_bwe`=4'b0001.
- **Back-pressure:** hold `glb_ready`=0 for 5 cycles after the first word forms.
  - `glb_*` stable throughout and `in_ready`=0.
  - After release, no byte lost or duplicated across 16 random bytes versus the reference model.
- **Wrap and ignored start:** `ADDR_W`=4, `base_addr`=0xF, 8 bytes.
  - Writes at 0xF then 0x0.
  - A `start` pulse mid-run is ignored; `wr_ptr` is unaffected.
- **Reset mid-run:** assert `rst_n`=0 asynchronously mid-cycle after 3 bytes.
  - All outputs go to 0 without waiting for a clock edge.
  - A new run then produces its first write at the new `base_addr` with no residue from the old lanes.
- **Simultaneous handshakes:** a word completes in the same cycle as `glb_ready` accepts the previous word.
  - `glb_we` stays 1, the new data and address appear next cycle, and no write is dropped.

Source files
------------

// File: rtl/ppu_out_packer.sv
// Packs the PPU uint8 activation stream into little-endian 32-bit GLB words.
// A held write request with byte enables waits for glb_ready; trailing partial words are masked.
module ppu_out_packer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              glb_we,
  input  logic              glb_ready,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [31:0]       glb_wdata,
  output logic [3:0]        glb_bwe,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start, input closed
  // ACTIVE | accepting bytes, assembling words
  // DRAIN  | in_last seen, waiting for the final write to be accepted
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        lane_cnt;
  logic [31:0]       asm_data, asm_data_nxt;
  logic [3:0]        asm_be, asm_be_nxt;
  logic              in_hs, wr_hs, word_done;

  assign in_hs     = in_valid & in_ready;
  assign wr_hs     = glb_we & glb_ready;
  assign word_done = in_hs & ((lane_cnt == 2'd3) | in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ACTIVE;
      S_ACTIVE: if (in_hs && in_last) state_nxt = S_DRAIN;
      S_DRAIN:  if (!glb_we || glb_ready) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // in_ready depends on state and glb_ready only, never on in_valid
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_ACTIVE: in_ready = !glb_we || glb_ready;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Unfilled lanes stay zero because the assembly register clears after every word.
  always_comb begin
    asm_data_nxt = asm_data;
    asm_be_nxt   = asm_be;
    asm_data_nxt[8*lane_cnt +: 8] = in_data;
    asm_be_nxt[lane_cnt]          = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      lane_cnt  <= '0;
      asm_data  <= '0;
      asm_be    <= '0;
      glb_we    <= 1'b0;
      glb_addr  <= '0;
      glb_wdata <= '0;
      glb_bwe   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        wr_ptr   <= base_addr;
        lane_cnt <= '0;
        asm_data <= '0;
        asm_be   <= '0;
      end
      if (in_hs) begin
        if (word_done) begin
          glb_wdata <= asm_data_nxt;
          glb_bwe   <= asm_be_nxt;
          glb_addr  <= wr_ptr;
          wr_ptr    <= wr_ptr + ADDR_W'(1);
          asm_data  <= '0;
          asm_be    <= '0;
          lane_cnt  <= '0;
        end else begin
          asm_data  <= asm_data_nxt;
          asm_be    <= asm_be_nxt;
          lane_cnt  <= lane_cnt + 2'd1;
        end
      end
      // a word completing in the same cycle as acceptance keeps the request up
      if (word_done)  glb_we <= 1'b1;
      else if (wr_hs) glb_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_out_packer.sv
// Scoreboarded random/directed bench for ppu_out_packer.
// Expected GLB writes come from a byte-list packing model; a negedge monitor pops and compares.
module tb_ppu_out_packer;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        glb_we;
  logic        glb_ready;
  logic [15:0] glb_addr;
  logic [31:0] glb_wdata;
  logic [3:0]  glb_bwe;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_wr_cyc = -100;
  int prev_wr_cyc = -100;
  logic [15:0] last_addr;
  logic [31:0] last_data;
  logic [3:0]  last_be;
  logic        done_d = 1'b0;
  int          ready_mode = 0;  // 0: tied high, 1: random, 2: manual
  wr_t         exp_q[$];

  ppu_out_packer #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .glb_we(glb_we), .glb_ready(glb_ready), .glb_addr(glb_addr),
    .glb_wdata(glb_wdata), .glb_bwe(glb_bwe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      glb_ready = 1'b1;
    else if (ready_mode == 1) glb_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (rst_n && glb_we && glb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h bwe=%h", glb_addr, glb_wdata, glb_bwe);
      end else begin
        e = exp_q.pop_front();
        check("write", {glb_addr, glb_wdata, glb_bwe}, {e.addr, e.data, e.be});
      end
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      last_addr = glb_addr;
      last_data = glb_wdata;
      last_be   = glb_bwe;
    end
    if (done) begin
      done_cnt++;
      check("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
      if (done_d) check("done_width", 64'd2, 64'd1);
    end
    done_d = done;
  end

  // Reference: byte list -> little-endian words, consecutive addresses, lane mask = bytes present.
  task automatic model_push(input logic [15:0] base, input logic [7:0] bytes[$]);
    int n = bytes.size();
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.addr = 16'(base + 16'(w));
      e.data = '0;
      e.be   = '0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < n) begin
          e.data = e.data | (32'(bytes[w*4+k]) << (8 * k));
          e.be   = e.be | 4'(1 << k);
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [15:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output int stalls);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("in_ready_timeout", 64'd0, 64'd1);
    stalls = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int run_stalls;

  task automatic run(input logic [15:0] base, input int n, input bit rnd,
                     input logic [7:0] first, input bit mid_start);
    logic [7:0] bytes[$];
    int d0, t, s;
    for (int i = 0; i < n; i++) bytes.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
    model_push(base, bytes);
    d0 = done_cnt;
    run_stalls = 0;
    do_start(base);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == 3) begin
        start = 1'b1;
        base_addr = 16'h1234;
      end
      send_byte(bytes[i], i == n - 1, s);
      run_stalls += s;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      t++;
      @(negedge clk);
    end
    check("done_seen", 64'(done_cnt), 64'(d0 + 1));
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    logic [51:0] held;
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; glb_ready = 1'b1;
    #3;
    check("reset_outs", {in_ready, glb_we, busy, done, glb_addr, glb_wdata, glb_bwe}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // full words, no bubbles
    run(16'h0010, 8, 0, 8'h01, 0);
    check("full_no_stall", 64'(run_stalls), 64'd0);
    check("full_last_data", {last_addr, last_data, last_be}, {16'h0011, 32'h08070605, 4'hF});

    // partial flush and single byte
    run(16'h0100, 6, 0, 8'hA0, 0);
    check("partial_last", {last_data, last_be}, {32'h0000A5A4, 4'b0011});
    run(16'h0200, 1, 0, 8'h7F, 0);
    check("single_byte", {last_addr, last_data, last_be}, {16'h0200, 32'h0000007F, 4'b0001});

    // simultaneous accept + new word: consecutive write cycles
    run(16'h0300, 5, 1, 8'h00, 0);
    check("back_to_back_wr", 64'(last_wr_cyc - prev_wr_cyc), 64'd1);

    // wrap with ignored mid-run start
    run(16'hFFFF, 8, 1, 8'h00, 1);
    check("wrap_addr", 64'(last_addr), 64'h0000);

    // input offered while idle is not consumed
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // back-pressure: hold glb_ready low for 5 cycles after first word forms
    ready_mode = 2;
    glb_ready = 1'b0;
    fork
      run(16'h0400, 16, 1, 8'h00, 0);
      begin
        int t = 0;
        @(negedge clk);
        while (!glb_we && t < 100) begin
          t++;
          @(negedge clk);
        end
        check("bp_we_seen", 64'(glb_we), 64'd1);
        held = {glb_addr, glb_wdata, glb_bwe};
        repeat (5) begin
          check("bp_stable", {glb_we, in_ready, glb_addr, glb_wdata, glb_bwe}, {1'b1, 1'b0, held});
          @(negedge clk);
        end
        ready_mode = 1;
      end
    join

    // random runs
    for (int r = 0; r < 10; r++) begin
      ready_mode = int'($urandom_range(0, 1));
      run(16'($urandom), int'($urandom_range(1, 12)), 1, 8'h00, 0);
    end
    ready_mode = 0;

    // reset mid-run after 3 bytes
    do_start(16'h0500);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, s);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {in_ready, glb_we, busy, done, glb_addr, glb_wdata, glb_bwe}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run(16'h0600, 4, 0, 8'hC0, 0);
    check("post_reset_wr", {last_addr, last_data, last_be}, {16'h0600, 32'hC3C2C1C0, 4'hF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
